// File: rtl/vga_pixel_fetch_pkg.sv
// Shared VGA types and constants: pixel/RGB types, idle sync levels, 1024x600 timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pixel_fetch_pkg;

    // Frame-buffer intensity width
    localparam int PIX_W_DEF = 4;

    // Idle levels for the sync outputs (HS active-low, VS active-high)
    localparam logic HS_IDLE = 1'b1;
    localparam logic VS_IDLE = 1'b0;

    // Colour shown inside the visible area but outside the captured source frame
    localparam logic [23:0] BORDER_RGB_DEF = 24'h000000;

    // 1024x600 panel timing, shared with the timing generator
    localparam int H_VISIBLE = 1024;
    localparam int H_FRONT   = 24;
    localparam int H_SYNC    = 136;
    localparam int H_BACK    = 160;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 3;
    localparam int V_SYNC    = 6;
    localparam int V_BACK    = 29;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Per-pixel flags that travel alongside the RAM read
    typedef struct packed {
        logic vis;     // active video
        logic in_src;  // inside the captured source frame
        logic test;    // checkerboard instead of RAM data
        logic chk;     // checkerboard cell colour
        logic en;      // output enabled for this pixel
    } pix_flags_t;

    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: HS_IDLE, vs: VS_IDLE};

    // 4-bit intensity to a green-phosphor RGB888 colour
    function automatic rgb_t phosphor_green(input logic [3:0] i);
        rgb_t c;
        c.r = 8'h00;
        c.g = {i, i};
        c.b = {2'b00, i, 2'b00};
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Frame-buffer read port: address + read strobe out, intensity data back.
// Latency: data returns a fixed number of cycles after the strobe (set by the RAM).
// Backpressure: none; the RAM must accept one read per cycle.
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 18,
    parameter int PIX_W  = 4
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [PIX_W-1:0]  ram_data;

    modport master (
        output ram_addr,
        output ram_rd,
        input  ram_data
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        output ram_data
    );
endinterface

// File: rtl/vga_pixel_fetch_delay_line.sv
// Fixed-depth register delay line with a configurable reset value.
// Latency: DEPTH cycles (DEPTH >= 1).
// Backpressure: none; shifts every cycle.
module vga_pixel_fetch_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift register; every stage loads the idle value on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= RESET_VAL;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches up-scaled frame-buffer pixels for the VGA timing stream, expands to RGB888, re-aligns HS/VS.
// Latency: X/Y/VISIBLE -> RGB/DE is RAM_LAT+2 cycles; HS/VS (which lag X/Y by one) are delayed RAM_LAT+1.
// Backpressure: none; one pixel per clock, ENABLE only masks the final output registers.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int          SRC_W_LOG2 = 9,
    parameter int          SRC_H      = 300,
    parameter int          H_SHIFT    = 1,
    parameter int          V_SHIFT    = 1,
    parameter int          ADDR_W     = 18,
    parameter int          PIX_W      = PIX_W_DEF,
    parameter int          RAM_LAT    = 2,
    parameter logic [23:0] BORDER_RGB = BORDER_RGB_DEF
) (
    input  logic               video_clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               test_pat,
    input  logic [11:0]        vga_x_i,
    input  logic [11:0]        vga_y_i,
    input  logic               vga_visible_i,
    input  logic               vga_hs_i,
    input  logic               vga_vs_i,
    vga_pixel_fetch_if.master  ram,
    output logic [7:0]         vga_red,
    output logic [7:0]         vga_green,
    output logic [7:0]         vga_blue,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de
);

    // ---------------- Stage 0: scale, bound and issue the read ----------------
    logic [11:0]       xs;
    logic [11:0]       ys;
    logic              in_src;
    logic              rd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    pix_flags_t        flags_nxt;
    pix_flags_t        flags0;

    // Source coordinates and bounds; blanking X/Y are ignored via VISIBLE
    always_comb begin
        xs        = vga_x_i >> H_SHIFT;
        ys        = vga_y_i >> V_SHIFT;
        in_src    = vga_visible_i
                    && (int'(xs) < (1 << SRC_W_LOG2))
                    && (int'(ys) < SRC_H);
        rd_nxt    = in_src && !test_pat;
        addr_nxt  = ADDR_W'({ys[8:0], xs[SRC_W_LOG2-1:0]});
        flags_nxt = '{vis:    vga_visible_i,
                      in_src: in_src,
                      test:   test_pat,
                      chk:    vga_x_i[5] ^ vga_y_i[5],
                      en:     enable};
    end

    // Input register; address only moves when a read is issued
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            ram.ram_rd   <= 1'b0;
            ram.ram_addr <= '0;
            flags0       <= '0;
        end else begin
            ram.ram_rd <= rd_nxt;
            if (rd_nxt) begin
                ram.ram_addr <= addr_nxt;
            end
            flags0 <= flags_nxt;
        end
    end

    // ---------------- Stages 1..RAM_LAT: flags wait for the RAM ----------------
    pix_flags_t flags_f;

    vga_pixel_fetch_delay_line #(
        .WIDTH     ($bits(pix_flags_t)),
        .DEPTH     (RAM_LAT),
        .RESET_VAL ('0)
    ) u_flag_pipe (
        .clk   (video_clk),
        .rst_n (reset_n),
        .din   (flags0),
        .dout  (flags_f)
    );

    // Sync arrives one cycle after X/Y, so it needs one stage less before the output register
    sync_t sync_in;
    sync_t sync_f;

    assign sync_in = '{hs: vga_hs_i, vs: vga_vs_i};

    vga_pixel_fetch_delay_line #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (RAM_LAT),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_pipe (
        .clk   (video_clk),
        .rst_n (reset_n),
        .din   (sync_in),
        .dout  (sync_f)
    );

    // ---------------- Final stage: colour select and output register ----------------
    rgb_t pix_rgb;
    rgb_t rgb_q;

    // Colour priority: blank, test pattern, RAM pixel, border
    always_comb begin
        pix_rgb = '0;
        if (!flags_f.vis) begin
            pix_rgb = '0;
        end else if (flags_f.test) begin
            pix_rgb = flags_f.chk ? 24'hFFFFFF : 24'h000000;
        end else if (flags_f.in_src) begin
            pix_rgb = phosphor_green(4'(ram.ram_data));
        end else begin
            pix_rgb = BORDER_RGB;
        end
    end

    // Output register; the pixel's own ENABLE forces blank with inactive syncs
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q  <= '0;
            vga_de <= 1'b0;
            vga_hs <= HS_IDLE;
            vga_vs <= VS_IDLE;
        end else if (!flags_f.en) begin
            rgb_q  <= '0;
            vga_de <= 1'b0;
            vga_hs <= HS_IDLE;
            vga_vs <= VS_IDLE;
        end else begin
            rgb_q  <= pix_rgb;
            vga_de <= flags_f.vis;
            vga_hs <= sync_f.hs;
            vga_vs <= sync_f.vs;
        end
    end

    assign vga_red   = rgb_q.r;
    assign vga_green = rgb_q.g;
    assign vga_blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a 2-cycle frame-buffer RAM model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each pixel applied before posedge e0 is expected on the output after posedge e3.
module tb_vga_pixel_fetch;

    localparam logic [23:0] BORDER = 24'h123456;
    localparam int          N_EN   = 420;

    logic        video_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        test_pat;
    logic [11:0] vx;
    logic [11:0] vy;
    logic        vvis;
    logic        vhs;
    logic        vvs;
    logic [7:0]  vga_red;
    logic [7:0]  vga_green;
    logic [7:0]  vga_blue;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;

    int checks = 0;
    int fails  = 0;

    vga_pixel_fetch_if #(.ADDR_W(18), .PIX_W(4)) ram_bus ();

    vga_pixel_fetch #(
        .SRC_W_LOG2 (9),
        .SRC_H      (300),
        .H_SHIFT    (1),
        .V_SHIFT    (1),
        .ADDR_W     (18),
        .PIX_W      (4),
        .RAM_LAT    (2),
        .BORDER_RGB (BORDER)
    ) dut (
        .video_clk     (video_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .test_pat      (test_pat),
        .vga_x_i       (vx),
        .vga_y_i       (vy),
        .vga_visible_i (vvis),
        .vga_hs_i      (vhs),
        .vga_vs_i      (vvs),
        .ram           (ram_bus.master),
        .vga_red       (vga_red),
        .vga_green     (vga_green),
        .vga_blue      (vga_blue),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_de        (vga_de)
    );

    always #5 video_clk = ~video_clk;

    // Frame-buffer contents as a function of address
    function automatic logic [3:0] ram_val(input logic [17:0] a);
        return ~(a[3:0] ^ a[7:4]);
    endfunction

    // Two-cycle RAM: address sampled on one edge, data visible after the next
    logic [3:0] q1;
    logic [3:0] q2;
    always @(posedge video_clk) begin
        q1 <= ram_val(ram_bus.ram_addr);
        q2 <= q1;
    end
    assign ram_bus.ram_data = q2;

    // Reference colour for one pixel
    function automatic logic [23:0] exp_pix(input int x, input int y, input bit vis, input bit tp);
        int          xs;
        int          ys;
        logic [3:0]  i;
        logic [17:0] a;
        xs = x / 2;
        ys = y / 2;
        if (!vis) return 24'h000000;
        if (tp) return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
        if (xs < 512 && ys < 300) begin
            a = 18'(ys * 512 + xs);
            i = ram_val(a);
            return {8'h00, i, i, 2'b00, i, 2'b00};
        end
        return BORDER;
    endfunction

    task automatic step();
        @(negedge video_clk);
    endtask

    task automatic set_in(input int x, input int y, input bit vis, input bit hs, input bit vs);
        vx   = 12'(x);
        vy   = 12'(y);
        vvis = vis;
        vhs  = hs;
        vvs  = vs;
    endtask

    task automatic idle(input int n);
        set_in(4095, 4095, 0, 1, 0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [27:0] got;
        enable   = 1'b1;
        test_pat = 1'b0;
        set_in(10, 7, 1, 1, 0);
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            got = {vga_red, vga_green, vga_blue, vga_de, vga_hs, vga_vs, ram_bus.ram_rd};
            checks++;
            if (got !== {24'h000000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", c, got, {24'h0, 4'b0100});
            end
        end
        checks++;
        if (ram_bus.ram_addr !== 18'd0) begin
            fails++;
            $display("FAIL reset_addr: got %0d want 0", ram_bus.ram_addr);
        end
        reset_n = 1'b1;
        idle(6);
    endtask

    task automatic test_address_map();
        idle(4);
        set_in(10, 7, 1, 1, 0);
        step();
        checks++;
        if (ram_bus.ram_rd !== 1'b1 || ram_bus.ram_addr !== 18'd1541) begin
            fails++;
            $display("FAIL addr_map: got rd=%b addr=%0d want rd=1 addr=1541",
                     ram_bus.ram_rd, ram_bus.ram_addr);
        end
        idle(6);
    endtask

    task automatic test_latency_colour();
        idle(6);
        set_in(10, 7, 1, 1, 0);
        step();                                // n1: HS edge one cycle after the pixel
        set_in(4095, 4095, 0, 0, 0);
        step();
        step();                                // n3: pixel not yet out
        checks++;
        if (vga_de !== 1'b0 || vga_hs !== 1'b1) begin
            fails++;
            $display("FAIL latency_early: got de=%b hs=%b want de=0 hs=1", vga_de, vga_hs);
        end
        step();                                // n4: pixel and HS edge together
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h00AA28 || vga_de !== 1'b1 || vga_hs !== 1'b0) begin
            fails++;
            $display("FAIL latency_colour: got rgb=%h de=%b hs=%b want rgb=00aa28 de=1 hs=0",
                     {vga_red, vga_green, vga_blue}, vga_de, vga_hs);
        end
        set_in(4095, 4095, 0, 1, 0);
        step();                                // n5: following blank pixel
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h000000 || vga_de !== 1'b0) begin
            fails++;
            $display("FAIL latency_after: got rgb=%h de=%b want rgb=000000 de=0",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        idle(6);
    endtask

    task automatic test_border();
        idle(6);
        set_in(1023, 599, 1, 1, 0);
        step();                                // n1
        checks++;
        if (ram_bus.ram_rd !== 1'b1 || ram_bus.ram_addr !== 18'd153599) begin
            fails++;
            $display("FAIL border_last_addr: got rd=%b addr=%0d want rd=1 addr=153599",
                     ram_bus.ram_rd, ram_bus.ram_addr);
        end
        set_in(1023, 600, 1, 1, 0);
        step();                                // n2
        checks++;
        if (ram_bus.ram_rd !== 1'b0 || ram_bus.ram_addr !== 18'd153599) begin
            fails++;
            $display("FAIL border_no_read: got rd=%b addr=%0d want rd=0 addr=153599",
                     ram_bus.ram_rd, ram_bus.ram_addr);
        end
        set_in(4095, 4095, 0, 1, 0);
        step();
        step();                                // n4
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h00FF3C || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL border_last_pixel: got rgb=%h de=%b want rgb=00ff3c de=1",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        step();                                // n5
        checks++;
        if ({vga_red, vga_green, vga_blue} !== BORDER || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL border_colour: got rgb=%h de=%b want rgb=%h de=1",
                     {vga_red, vga_green, vga_blue}, vga_de, BORDER);
        end
        idle(6);
    endtask

    task automatic test_test_pat();
        idle(6);
        test_pat = 1'b1;
        set_in(0, 0, 1, 1, 0);
        step();                                // n1
        checks++;
        if (ram_bus.ram_rd !== 1'b0) begin
            fails++;
            $display("FAIL testpat_rd0: got rd=%b want 0", ram_bus.ram_rd);
        end
        set_in(32, 0, 1, 1, 0);
        step();                                // n2
        checks++;
        if (ram_bus.ram_rd !== 1'b0) begin
            fails++;
            $display("FAIL testpat_rd1: got rd=%b want 0", ram_bus.ram_rd);
        end
        test_pat = 1'b0;
        set_in(4095, 4095, 0, 1, 0);
        step();
        step();                                // n4
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h000000 || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL testpat_dark: got rgb=%h de=%b want rgb=000000 de=1",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        step();                                // n5
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'hFFFFFF || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL testpat_light: got rgb=%h de=%b want rgb=ffffff de=1",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        idle(6);
    endtask

    task automatic test_blanking();
        idle(6);
        set_in(4095, 4095, 0, 1, 0);
        step();
        checks++;
        if (ram_bus.ram_rd !== 1'b0) begin
            fails++;
            $display("FAIL blank_no_read: got rd=%b want 0", ram_bus.ram_rd);
        end
        set_in(2, 4094, 0, 1, 0);
        step();
        checks++;
        if (ram_bus.ram_rd !== 1'b0) begin
            fails++;
            $display("FAIL blank_no_read_small_x: got rd=%b want 0", ram_bus.ram_rd);
        end
        step();
        step();
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h000000 || vga_de !== 1'b0) begin
            fails++;
            $display("FAIL blank_output: got rgb=%h de=%b want rgb=000000 de=0",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        idle(6);
    endtask

    task automatic test_reset_midframe();
        set_in(10, 7, 1, 1, 0);
        repeat (6) step();
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h00AA28 || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL midreset_before: got rgb=%h de=%b want rgb=00aa28 de=1",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h000000 || vga_de !== 1'b0
            || vga_hs !== 1'b1 || ram_bus.ram_rd !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: got rgb=%h de=%b hs=%b rd=%b want 000000/0/1/0",
                     {vga_red, vga_green, vga_blue}, vga_de, vga_hs, ram_bus.ram_rd);
        end
        step();
        reset_n = 1'b1;                        // pixel is already applied at release
        step();
        step();
        step();                                // n3
        checks++;
        if (vga_de !== 1'b0) begin
            fails++;
            $display("FAIL midreset_refill: got de=%b want 0", vga_de);
        end
        step();                                // n4
        checks++;
        if ({vga_red, vga_green, vga_blue} !== 24'h00AA28 || vga_de !== 1'b1) begin
            fails++;
            $display("FAIL midreset_first_pixel: got rgb=%h de=%b want rgb=00aa28 de=1",
                     {vga_red, vga_green, vga_blue}, vga_de);
        end
        idle(6);
    endtask

    task automatic test_enable();
        int          ax   [N_EN];
        int          ay   [N_EN];
        bit          avis [N_EN];
        bit          ahs  [N_EN];
        bit          avs  [N_EN];
        bit          aen  [N_EN];
        bit          atp  [N_EN];
        logic [26:0] got;
        logic [26:0] want;
        int          j;
        idle(6);
        for (int k = 0; k < N_EN; k++) begin
            if (k >= 4) begin
                j   = k - 4;
                got = {vga_red, vga_green, vga_blue, vga_de, vga_hs, vga_vs};
                if (!aen[j]) want = {24'h000000, 1'b0, 1'b1, 1'b0};
                else         want = {exp_pix(ax[j], ay[j], avis[j], atp[j]), avis[j], ahs[j+1], avs[j+1]};
                checks++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL enable_stream k=%0d: got %h want %h", k, got, want);
                end
            end
            ax[k]   = 2 * k + 300;
            ay[k]   = 100 + k / 64;
            avis[k] = (k % 97) < 90;
            ahs[k]  = !((k % 97) >= 92 && (k % 97) < 95);
            avs[k]  = (k % 130) < 4;
            aen[k]  = !(k >= 100 && k < 200);
            atp[k]  = (k >= 250 && k < 280);
            enable   = aen[k];
            test_pat = atp[k];
            set_in(ax[k], ay[k], avis[k], ahs[k], avs[k]);
            step();
        end
        enable   = 1'b1;
        test_pat = 1'b0;
        idle(6);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        test_pat = 1'b0;
        set_in(4095, 4095, 0, 1, 0);
        test_reset();
        test_address_map();
        test_latency_colour();
        test_border();
        test_test_pat();
        test_blanking();
        test_reset_midframe();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
